// File: rtl/fire2_pkg.sv
// Shared constants and types for the fire2 expand-1x1 output feature-map writer.
package fire2_pkg;
  localparam int WIDTH    = 16;
  localparam int DSP_NO   = 64;
  localparam int W_IN     = 64;
  localparam int H_IN     = 64;
  localparam int WR_LANES = 4;

  localparam int PIXELS = W_IN * H_IN;
  localparam int BEATS  = DSP_NO / WR_LANES;
  localparam int ADDR_W = $clog2(BEATS * PIXELS);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int PIX_W  = $clog2(PIXELS);
  localparam int CH_W   = $clog2(DSP_NO);

  typedef logic [0:DSP_NO-1][WIDTH-1:0] ofm_vec_t;
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} wr_state_t;
endpackage

// File: rtl/fire2_expand_1_ofm_writer_buf.sv
// Two-entry ping-pong vector buffer: one entry fills while the other drains.
module ofm_pingpong_buf
  import fire2_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [0:DSP_NO-1][WIDTH-1:0]  push_vec,
  input  logic                          pop,
  output logic [0:DSP_NO-1][WIDTH-1:0]  rd_vec_nxt,
  output logic [1:0]                    valid,
  output logic                          full
);
  ofm_vec_t   mem [2];
  logic       wptr;
  logic       rptr;
  logic       do_push;
  logic [1:0] set_v;
  logic [1:0] clr_v;

  assign full    = &valid;
  assign do_push = push & ~full;
  assign set_v   = do_push ? (wptr ? 2'b10 : 2'b01) : 2'b00;
  assign clr_v   = pop ? (rptr ? 2'b10 : 2'b01) : 2'b00;

  // The reader sees the entry it will own next cycle, so beat 0 of a
  // back-to-back vector can be registered on the same edge the old one frees.
  assign rd_vec_nxt = mem[rptr ^ pop];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      valid <= 2'b00;
    end else begin
      if (do_push) wptr <= ~wptr;
      if (pop)     rptr <= ~rptr;
      valid <= (valid & ~clr_v) | set_v;
    end
  end

  // NOTE: the payload storage is deliberately not reset; the valid bits alone
  // decide which entry is live, and resetting wide storage only costs logic.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_vec;
  end
endmodule

// File: rtl/fire2_expand_1_ofm_writer.sv
// Writes each 64-channel pixel vector into WR_LANES banks in channel-major order.
module fire2_expand_1_ofm_writer
  import fire2_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             layer_en,
  input  logic                             ofm_valid,
  input  logic [0:DSP_NO-1][WIDTH-1:0]     ofm,
  output logic [WR_LANES-1:0]              wr_en,
  output logic [0:WR_LANES-1][ADDR_W-1:0]  wr_addr,
  output logic [0:WR_LANES-1][WIDTH-1:0]   wr_data,
  output logic                             busy,
  output logic                             done,
  output logic                             overrun
);
  wr_state_t                      state, state_nxt;
  logic [BEAT_W-1:0]              beat, beat_nxt;
  logic [PIX_W-1:0]               pix, pix_nxt;
  logic                           push;
  logic                           last_beat;
  logic [1:0]                     buf_valid;
  logic                           buf_full;
  ofm_vec_t                       rd_vec;
  logic [ADDR_W-1:0]              addr_nxt;
  logic [0:WR_LANES-1][WIDTH-1:0] lane_data;

  assign push      = ofm_valid & layer_en & (state != DONE);
  assign last_beat = (state == DRAIN) && (beat == BEAT_W'(BEATS - 1));

  ofm_pingpong_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_vec   (ofm),
    .pop        (last_beat),
    .rd_vec_nxt (rd_vec),
    .valid      (buf_valid),
    .full       (buf_full)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_nxt = state;
    beat_nxt  = beat;
    pix_nxt   = pix;
    unique case (state)
      IDLE: if (|buf_valid) state_nxt = DRAIN;
      DRAIN: begin
        if (last_beat) begin
          beat_nxt = '0;
          if (pix == PIX_W'(PIXELS - 1)) begin
            state_nxt = DONE;
          end else begin
            pix_nxt = pix + 1'b1;
            // While draining, a full buffer means the other entry is already waiting.
            state_nxt = buf_full ? DRAIN : IDLE;
          end
        end else begin
          beat_nxt = beat + 1'b1;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so the lane mux works on the next beat and pixel.
  always_comb begin
    addr_nxt  = ADDR_W'(beat_nxt) * ADDR_W'(PIXELS) + ADDR_W'(pix_nxt);
    lane_data = '0;
    for (int l = 0; l < WR_LANES; l++) begin
      lane_data[l] = rd_vec[CH_W'(beat_nxt) * CH_W'(WR_LANES) + CH_W'(l)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      beat    <= '0;
      pix     <= '0;
      overrun <= 1'b0;
      wr_en   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      pix   <= pix_nxt;
      if (push && buf_full) overrun <= 1'b1;
      wr_en <= {WR_LANES{state_nxt == DRAIN}};
      if (state_nxt == DRAIN) begin
        wr_data <= lane_data;
        for (int l = 0; l < WR_LANES; l++) wr_addr[l] <= addr_nxt;
      end
    end
  end

  assign busy = (|buf_valid) | (state == DRAIN);
  assign done = (state == DONE);
endmodule
